// File: rtl/mem_stage_dm_pkg.sv
// Shared memory-op definitions for the MEM stage: MIPS load/store opcodes,
// the internal memory-op encoding, and the opcode decoder.
package mem_stage_dm_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    // Access width plus signedness; stores only ever use WORD/HALF/BYTE.
    typedef enum logic [2:0] {
        MEMOP_NONE   = 3'd0,
        MEMOP_WORD   = 3'd1,
        MEMOP_HALF   = 3'd2,
        MEMOP_HALF_U = 3'd3,
        MEMOP_BYTE   = 3'd4,
        MEMOP_BYTE_U = 3'd5
    } memop_e;

    typedef struct packed {
        logic   is_load;
        logic   is_store;
        memop_e memop;
    } memctl_t;

    function automatic memctl_t decode_memop(input logic [5:0] opcode);
        memctl_t c;
        c = '{is_load: 1'b0, is_store: 1'b0, memop: MEMOP_NONE};
        case (opcode)
            OP_LW:  c = '{is_load: 1'b1, is_store: 1'b0, memop: MEMOP_WORD};
            OP_LH:  c = '{is_load: 1'b1, is_store: 1'b0, memop: MEMOP_HALF};
            OP_LHU: c = '{is_load: 1'b1, is_store: 1'b0, memop: MEMOP_HALF_U};
            OP_LB:  c = '{is_load: 1'b1, is_store: 1'b0, memop: MEMOP_BYTE};
            OP_LBU: c = '{is_load: 1'b1, is_store: 1'b0, memop: MEMOP_BYTE_U};
            OP_SW:  c = '{is_load: 1'b0, is_store: 1'b1, memop: MEMOP_WORD};
            OP_SH:  c = '{is_load: 1'b0, is_store: 1'b1, memop: MEMOP_HALF};
            OP_SB:  c = '{is_load: 1'b0, is_store: 1'b1, memop: MEMOP_BYTE};
            default: c = '{is_load: 1'b0, is_store: 1'b0, memop: MEMOP_NONE};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_stage_dm_if.sv
// EX/MEM-facing bus of the memory stage, plus a store-commit trace channel.
// The trace channel carries what is about to be written on the next edge so
// a simulation-side monitor can print it; it has no effect on the datapath.
interface mem_stage_dm_if;
    logic [31:0] InstrIn;
    logic [31:0] ALUResultIn;
    logic [31:0] RData2In;
    logic [31:0] curPCIn;
    logic [31:0] ReadDataOut;
    logic        StoreActive;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_word;

    modport master (
        output InstrIn, ALUResultIn, RData2In, curPCIn,
        input  ReadDataOut, StoreActive,
        input  trace_valid, trace_pc, trace_addr, trace_word
    );

    modport slave (
        input  InstrIn, ALUResultIn, RData2In, curPCIn,
        output ReadDataOut, StoreActive,
        output trace_valid, trace_pc, trace_addr, trace_word
    );
endinterface

// File: rtl/mem_stage_dm_load_ext.sv
// Load lane select and extension: picks the addressed half/byte out of the
// read word and sign- or zero-extends it. MEMOP_NONE yields zero.
module mem_stage_dm_load_ext
    import mem_stage_dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  memop_e      memop,
    output logic [31:0] result
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Half select ignores offset[0]; misaligned halves are not trapped.
    always_comb begin
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Byte lane select, lane 0 is the least significant byte.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    // Extension according to the decoded access type.
    always_comb begin
        result = '0;
        case (memop)
            MEMOP_WORD:   result = word;
            MEMOP_HALF:   result = {{16{half_sel[15]}}, half_sel};
            MEMOP_HALF_U: result = {16'h0000, half_sel};
            MEMOP_BYTE:   result = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BYTE_U: result = {24'h000000, byte_sel};
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM stage data memory: word-organised RAM with read-modify-write merging
// for sh/sb, combinational (zero-latency) extending loads, and a store trace.
module mem_stage_dm
    import mem_stage_dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int TRACE_EN   = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_dm_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    memctl_t               ctl;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            offset;
    logic [31:0]           rd_word;
    logic [31:0]           merged;
    memop_e                load_op;
    logic                  unused_bits;

    assign ctl      = decode_memop(bus.InstrIn[31:26]);
    assign word_idx = bus.ALUResultIn[DEPTH_LOG2+1:2];
    assign offset   = bus.ALUResultIn[1:0];
    assign rd_word  = mem[word_idx];
    assign load_op  = ctl.is_load ? ctl.memop : MEMOP_NONE;

    assign unused_bits = ^bus.InstrIn[25:0];

    // Merge the store data into the current word; untouched lanes keep old data.
    always_comb begin
        merged = rd_word;
        if (ctl.is_store) begin
            case (ctl.memop)
                MEMOP_WORD: merged = bus.RData2In;
                MEMOP_HALF: begin
                    if (offset[1]) merged[31:16] = bus.RData2In[15:0];
                    else           merged[15:0]  = bus.RData2In[15:0];
                end
                MEMOP_BYTE: begin
                    case (offset)
                        2'd0:    merged[7:0]   = bus.RData2In[7:0];
                        2'd1:    merged[15:8]  = bus.RData2In[7:0];
                        2'd2:    merged[23:16] = bus.RData2In[7:0];
                        default: merged[31:24] = bus.RData2In[7:0];
                    endcase
                end
                default: merged = rd_word;
            endcase
        end
    end

    // Synchronous clear of the whole array; reset wins over a concurrent store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (ctl.is_store) begin
            mem[word_idx] <= merged;
        end
    end

    mem_stage_dm_load_ext u_load_ext (
        .word   (rd_word),
        .offset (offset),
        .memop  (load_op),
        .result (bus.ReadDataOut)
    );

    assign bus.StoreActive = ctl.is_store;

    // Trace channel: describes the store that commits on the coming edge.
    assign bus.trace_valid = (TRACE_EN != 0) && ctl.is_store && !reset;
    assign bus.trace_pc    = bus.curPCIn;
    assign bus.trace_addr  = {bus.ALUResultIn[31:2], 2'b00};
    assign bus.trace_word  = merged;

endmodule

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
Memory-access stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its instruction, ALU result (effective address), store data and PC. The block holds the data memory and performs word, half-word and byte stores with read-modify-write merging. It also performs sign- and zero-extending loads and delivers the loaded value toward the MEM/WB register.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB)
TRACE_EN, 1, when 1 every committed store prints a trace line

Ports:
clk  input  1  clock
reset  input  1  reset
InstrIn  input  32  instruction currently in MEM (from EX/MEM register)
ALUResultIn  input  32  effective byte address (base + imm)
RData2In  input  32  store data (rt), already forwarded by the hazard unit
curPCIn  input  32  PC of the instruction in MEM, used for trace only
ReadDataOut  output  32  extended load result; 0 for non-load instructions
StoreActive  output  1  1 when InstrIn is a store this cycle, for debug/verification

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On a posedge with reset=1, all DEPTH words clear to 0 and any store presented that cycle is suppressed.
- Outputs are combinational from the inputs and the memory state. After reset with InstrIn=0 (nop): ReadDataOut=0 and StoreActive=0.
- Decode uses opcode InstrIn[31:26]:
  - sw 101011, sh 101001, sb 101000
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
  - any other opcode is neither a load nor a store.
- Address handling:
  - word index = ALUResultIn[DEPTH_LOG2+1:2]
  - byte offset = ALUResultIn[1:0]
  - higher address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
- Alignment: sw/lw use offset as-is and assume 0. sh/lh/lhu use offset[1] only (half select); offset[0] is ignored. No exception is raised.
- Store, committed at posedge when reset=0:
  - sw writes the full word.
  - sh writes RData2In[15:0] into half offset[1] (0 = bits 15:0, 1 = bits 31:16).
  - sb writes RData2In[7:0] into byte lane offset (lane 0 = bits 7:0).
  - The other lanes keep their old contents.
- Load is combinational, zero-cycle latency within MEM:
  - lw returns the word.
  - lh/lhu select a half by offset[1], then sign- or zero-extend it.
  - lb/lbu select a byte by offset, then sign- or zero-extend it.
- Read-after-write: a load in the cycle after a store to the same word sees the merged new value.
- Trace: when TRACE_EN=1, each committed store prints "time@curPC: *wordaddr <= mergedword".
  - wordaddr is the byte address with bits [1:0] forced to 0.
  - mergedword is the full 32-bit value after merging.
  - No trace line is printed while reset=1.
- Unknown opcodes have no memory side effect and produce ReadDataOut=0.

Decomposition:
- A shared package holds the opcode constants (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB) and the memory-op encoding (MEMOP_NONE, WORD, HALF, HALF_U, BYTE, BYTE_U). The decoder and the hazard unit both reuse them.
- One natural sub-module, dm_load_ext, holds the combinational lane-select and extension logic: word + offset + memop in, 32-bit result out.

Test Plan:
- Reset → nop: after reset, InstrIn=0 with ALUResultIn=0x10 → ReadDataOut=0x00000000 and StoreActive=0.
- Word store then load: sw with addr 0x4, data 0xDEADBEEF, then lw addr 0x4 next cycle → ReadDataOut=0xDEADBEEF; trace line "@pc: *00000004 <= deadbeef".
- Byte merge then byte loads:
  - Setup: word 0x8 = 0x11223344, then sb addr 0x9 with data 0x000000F0.
  - Expect word = 0x1122F044.
  - lb 0x9 → 0xFFFFFFF0; lbu 0x9 → 0x000000F0.
- Half merge and half loads:
  - sh addr 0xE with data 0x00008001 onto a zeroed word 0xC → word = 0x80010000.
  - lh 0xE → 0xFFFF8001; lhu 0xE → 0x00008001; lh 0xC → 0x00000000.
- Wrap and reset mid-operation:
  - sw addr 0x1000 with DEPTH_LOG2=10 writes word 0; lw 0x0 returns that data.
  - Asserting reset in the same cycle as an sw suppresses the write, clears memory, and a following lw returns 0.
